// File: rtl/hpc2_and_arbiter.sv
// Arbitrates one shared pipelined HPC2 masked AND gadget among NUM_REQ requesters and routes results back by tag.
// Build option: define HPC2_ARB_RR_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module hpc2_and_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned SHARES  = 3,
  parameter int unsigned W       = 1,
  parameter int unsigned LAT     = 2,
  localparam int unsigned RW     = SHARES * (SHARES - 1) / 2 * W,
  localparam int unsigned SW     = SHARES * W,
  localparam int unsigned TAG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*SW-1:0] req_a,
  input  logic [NUM_REQ*SW-1:0] req_b,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  input  logic [RW-1:0]         rnd_in,
  output logic [SW-1:0]         g_a,
  output logic [SW-1:0]         g_b,
  output logic [RW-1:0]         g_r,
  output logic                  g_en,
  input  logic [SW-1:0]         g_c,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [SW-1:0]         rsp_c,
  output logic                  busy
);

  logic [LAT-1:0]            vld_q, vld_d;
  logic [LAT-1:0][TAG_W-1:0] tag_q, tag_d;
  logic                      adv;
  logic                      issue;
  logic [TAG_W-1:0]          grant;
  logic [NUM_REQ-1:0]        sel;

`ifdef HPC2_ARB_RR_EN
  logic [TAG_W-1:0] ptr_q, ptr_d;

  // First valid requester at or above the pointer, otherwise wrap to the lowest valid one.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (TAG_W'(i) >= ptr_q)) begin
        grant = TAG_W'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        grant = TAG_W'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        grant = TAG_W'(i);
        found = 1'b1;
      end
    end
  end
`endif

  // The pipeline only advances when its last stage is empty or being drained.
  always_comb begin
    adv   = !rst && (!vld_q[LAT-1] || rsp_ready);
    issue = adv && (|req_valid) && rnd_valid;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sel[i] = issue && (grant == TAG_W'(i));
    end
  end

  // AND-OR select per share index so distinct shares never share a logic cone.
  always_comb begin
    g_a = '0;
    g_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        g_a[j*W +: W] = g_a[j*W +: W] | (req_a[i*SW + j*W +: W] & {W{sel[i]}});
        g_b[j*W +: W] = g_b[j*W +: W] | (req_b[i*SW + j*W +: W] & {W{sel[i]}});
      end
    end
  end

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    if (adv) begin
      vld_d[0] = issue;
      tag_d[0] = grant;
      for (int unsigned k = 1; k < LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign req_ready = sel;
  assign rnd_ready = issue;
  assign g_r       = rnd_in & {RW{issue}};
  assign g_en      = adv;
  assign rsp_valid = vld_q[LAT-1] && !rst;
  assign rsp_tag   = tag_q[LAT-1];
  assign rsp_c     = g_c;
  assign busy      = |vld_q;

endmodule

// File: tb/tb_hpc2_and_arbiter.sv
// Bench for hpc2_and_arbiter: directed scenarios then random traffic against a behavioural model with a gadget stand-in.
module tb_hpc2_and_arbiter;

  localparam int NUM_REQ = 2;
  localparam int SHARES  = 3;
  localparam int W       = 1;
  localparam int LAT     = 2;
  localparam int RW      = SHARES * (SHARES - 1) / 2 * W;
  localparam int SW      = SHARES * W;
  localparam int TAG_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*SW-1:0] req_a, req_b;
  logic                  rnd_valid, rnd_ready;
  logic [RW-1:0]         rnd_in;
  logic [SW-1:0]         g_a, g_b, g_c, rsp_c;
  logic [RW-1:0]         g_r;
  logic                  g_en, rsp_valid, rsp_ready, busy;
  logic [TAG_W-1:0]      rsp_tag;

  int checks = 0;
  int errors = 0;
  int n_issue = 0;
  int n_rnd = 0;

  // Model of the in-flight operations: owner and expected unmasked result per stage.
  bit          m_vld [LAT];
  int          m_tag [LAT];
  logic [W-1:0] m_val [LAT];
  int          m_ptr = 0;

  logic [SW-1:0] gad_q [LAT];

  hpc2_and_arbiter #(.NUM_REQ(NUM_REQ), .SHARES(SHARES), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_in(rnd_in),
    .g_a(g_a), .g_b(g_b), .g_r(g_r), .g_en(g_en), .g_c(g_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_c(rsp_c),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] unmask(input logic [SW-1:0] s);
    logic [W-1:0] x = '0;
    for (int j = 0; j < SHARES; j++) x ^= s[j*W +: W];
    return x;
  endfunction

  // Stand-in gadget: correct sharing of a&b, randomness spread over the upper shares.
  function automatic logic [SW-1:0] gadget(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                           input logic [RW-1:0] r);
    logic [W-1:0]  x = unmask(a) & unmask(b);
    logic [SW-1:0] c = '0;
    for (int j = 1; j < SHARES; j++) begin
      c[j*W +: W] = r[(j-1)*W +: W];
      x ^= r[(j-1)*W +: W];
    end
    c[W-1:0] = x;
    return c;
  endfunction

  always @(posedge clk) begin
    if (g_en) begin
      gad_q[0] <= gadget(g_a, g_b, g_r);
      for (int k = 1; k < LAT; k++) gad_q[k] <= gad_q[k-1];
    end
  end
  assign g_c = gad_q[LAT-1];

  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
`ifdef HPC2_ARB_RR_EN
    for (int k = 0; k < NUM_REQ; k++) if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
`else
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
`endif
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle at the falling edge, then advance the model and move to just after the next rising edge.
  task automatic do_cycle();
    bit            adv, iss, any_vld;
    int            gnt;
    logic [NUM_REQ-1:0] rdy;
    logic [SW-1:0] ea, eb;
    logic [RW-1:0] er;
    @(negedge clk);
    adv = !rst && (!m_vld[LAT-1] || rsp_ready);
    gnt = pick(req_valid, m_ptr);
    iss = adv && (req_valid != '0) && rnd_valid;
    rdy = '0; ea = '0; eb = '0; er = '0;
    if (iss) begin
      rdy[gnt] = 1'b1;
      ea = req_a[gnt*SW +: SW];
      eb = req_b[gnt*SW +: SW];
      er = rnd_in;
    end
    any_vld = 1'b0;
    for (int k = 0; k < LAT; k++) any_vld |= m_vld[k];
    chk("g_en", 64'(g_en), 64'(adv));
    chk("rnd_ready", 64'(rnd_ready), 64'(iss));
    chk("req_ready", 64'(req_ready), 64'(rdy));
    chk("g_a", 64'(g_a), 64'(ea));
    chk("g_b", 64'(g_b), 64'(eb));
    chk("g_r", 64'(g_r), 64'(er));
    chk("rsp_valid", 64'(rsp_valid), 64'(!rst && m_vld[LAT-1]));
    chk("busy", 64'(busy), 64'(any_vld));
    if (!rst && m_vld[LAT-1]) begin
      chk("rsp_tag", 64'(rsp_tag), 64'(m_tag[LAT-1]));
      chk("rsp_unmasked", 64'(unmask(rsp_c)), 64'(m_val[LAT-1]));
    end
    if (rnd_ready) n_rnd++;
    if (iss) n_issue++;
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin m_vld[k] = 1'b0; m_tag[k] = 0; end
      m_ptr = 0;
    end else if (adv) begin
      for (int k = LAT - 1; k > 0; k--) begin
        m_vld[k] = m_vld[k-1]; m_tag[k] = m_tag[k-1]; m_val[k] = m_val[k-1];
      end
      m_vld[0] = iss;
      m_tag[0] = gnt;
      m_val[0] = unmask(ea) & unmask(eb);
      if (iss) m_ptr = (gnt + 1) % NUM_REQ;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*SW +: SW] = SW'($urandom);
      req_b[i*SW +: SW] = SW'($urandom);
    end
    rnd_in = RW'($urandom);
  endtask

  initial begin
    int target;
    for (int k = 0; k < LAT; k++) begin gad_q[k] = '0; m_vld[k] = 1'b0; m_tag[k] = 0; m_val[k] = '0; end
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    rnd_valid = 1'b0; rnd_in = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    repeat (2) do_cycle();
    rst = 1'b0;

    // Single operation from requester 0: a=101, b=011 -> unmasked result 0.
    req_valid = 2'b01; req_a[SW-1:0] = 3'b101; req_b[SW-1:0] = 3'b011;
    rnd_in = RW'($urandom); rnd_valid = 1'b1;
    do_cycle();
    req_valid = '0;
    repeat (3) do_cycle();

    // Both requesters contend for four cycles.
    req_valid = 2'b11;
    repeat (4) begin rand_data(); do_cycle(); end
    req_valid = '0;
    repeat (3) do_cycle();

    // Randomness starvation, then resume.
    req_valid = 2'b11; rnd_valid = 1'b0;
    repeat (3) begin rand_data(); do_cycle(); end
    rnd_valid = 1'b1;
    repeat (2) begin rand_data(); do_cycle(); end
    req_valid = '0;
    repeat (3) do_cycle();

    // Backpressure with a full pipeline.
    req_valid = 2'b11;
    repeat (2) begin rand_data(); do_cycle(); end
    rsp_ready = 1'b0;
    repeat (3) begin rand_data(); do_cycle(); end
    rsp_ready = 1'b1; req_valid = '0;
    repeat (4) do_cycle();

    // Reset with two operations in flight, then one fresh operation.
    req_valid = 2'b01;
    repeat (2) begin rand_data(); do_cycle(); end
    req_valid = '0; rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    do_cycle();
    req_valid = 2'b10; rand_data();
    do_cycle();
    req_valid = '0;
    repeat (LAT + 1) do_cycle();

    // Random traffic.
    target = n_issue + 1000;
    for (int cyc = 0; cyc < 20000 && n_issue < target; cyc++) begin
      req_valid = NUM_REQ'($urandom);
      rand_data();
      rnd_valid = ($urandom % 5) != 0;
      rsp_ready = ($urandom % 4) != 0;
      do_cycle();
    end
    chk("random_ops_done", 64'(n_issue >= target), 64'(1));
    req_valid = '0; rsp_ready = 1'b1; rnd_valid = 1'b1;
    repeat (LAT + 2) do_cycle();
    chk("rnd_count", 64'(n_rnd), 64'(n_issue));
    chk("busy_end", 64'(busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
